// File: rtl/vga_pkg.sv
// Shared VGA timing and framebuffer constants.
// Used by VGAController and the pixel fetch stage.
package vga_pkg;

    localparam int H_ACTIVE    = 640;
    localparam int V_ACTIVE    = 480;
    localparam int SCALE_SHIFT = 2;
    localparam int FB_W        = H_ACTIVE >> SCALE_SHIFT;
    localparam int FB_H        = V_ACTIVE >> SCALE_SHIFT;
    localparam int ADDR_W      = 16;
    localparam int OFF_W       = ADDR_W - 1;
    localparam int PIX_W       = 4;
    localparam int COL_W       = 12;
    localparam int PAL_N       = 1 << PIX_W;
    localparam int PIX_LAT     = 3;

    // FB_W = 160 = 128 + 32
    localparam int FB_W_SH_HI  = 7;
    localparam int FB_W_SH_LO  = 5;

    typedef enum logic {
        SWAP_IDLE,
        SWAP_PENDING
    } swap_state_e;

    function automatic logic [OFF_W-1:0] fb_offset(
        input logic [OFF_W-1:0] row,
        input logic [OFF_W-1:0] col
    );
        return (row << FB_W_SH_HI) + (row << FB_W_SH_LO) + col;
    endfunction

endpackage

// File: rtl/vga_palette_ram.sv
// 16-entry colour palette: one write port, one registered read port.
// Resets to a greyscale ramp; a lookup gated off returns black.
import vga_pkg::*;

module vga_palette_ram (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [PIX_W-1:0] waddr_i,
    input  logic [COL_W-1:0] wdata_i,
    input  logic             re_i,
    input  logic [PIX_W-1:0] raddr_i,
    output logic [COL_W-1:0] rdata_o
);

    logic [COL_W-1:0] mem_q [PAL_N];
    logic [COL_W-1:0] rdata_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < PAL_N; i++) begin
                mem_q[i] <= {3{PIX_W'(i)}};
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Reads the pre-write contents on a same-cycle write of that entry
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= re_i ? mem_q[raddr_i] : '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/vga_pixel_fetch.sv
// Framebuffer fetch, palette lookup, sync alignment and vblank buffer swap.
import vga_pkg::*;

module vga_pixel_fetch (
    input  logic              block_clk_i,
    input  logic              rst_i,
    input  logic [9:0]        h_count_i,
    input  logic [9:0]        v_count_i,
    input  logic              video_on_i,
    input  logic              h_sync_i,
    input  logic              v_sync_i,
    output logic [ADDR_W-1:0] fb_addr_o,
    input  logic [PIX_W-1:0]  fb_data_i,
    input  logic              pal_we_i,
    input  logic [3:0]        pal_addr_i,
    input  logic [COL_W-1:0]  pal_data_i,
    input  logic              swap_req_i,
    output logic              swap_ack_o,
    output logic              disp_buf_o,
    output logic [COL_W-1:0]  rgb_o,
    output logic              h_sync_o,
    output logic              v_sync_o
);

    logic [OFF_W-1:0]  row, col, off;
    logic [ADDR_W-1:0] addr_q;
    logic [PIX_LAT-1:0] hs_q, vs_q;
    logic [1:0]        von_q;

    swap_state_e state_q, state_d;
    logic        disp_buf_q, disp_buf_d;
    logic        ack_q, ack_d;
    logic        boundary, apply;

    assign row = OFF_W'(v_count_i >> SCALE_SHIFT);
    assign col = OFF_W'(h_count_i >> SCALE_SHIFT);
    assign off = fb_offset(row, col);

    always_ff @(posedge block_clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q <= '0;
            von_q  <= '0;
            hs_q   <= '1;
            vs_q   <= '1;
        end else begin
            addr_q <= video_on_i ? {disp_buf_q, off} : '0;
            von_q  <= {von_q[0], video_on_i};
            hs_q   <= {hs_q[PIX_LAT-2:0], h_sync_i};
            vs_q   <= {vs_q[PIX_LAT-2:0], v_sync_i};
        end
    end

    // fb_data_i lags addr_q by one cycle, matching von_q[1]
    vga_palette_ram u_pal (
        .clk_i   (block_clk_i),
        .rst_i   (rst_i),
        .we_i    (pal_we_i),
        .waddr_i (pal_addr_i),
        .wdata_i (pal_data_i),
        .re_i    (von_q[1]),
        .raddr_i (fb_data_i),
        .rdata_o (rgb_o)
    );

    assign boundary = (v_count_i == 10'(V_ACTIVE)) && (h_count_i == '0);

    always_ff @(posedge block_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= SWAP_IDLE;
            disp_buf_q <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            disp_buf_q <= disp_buf_d;
            ack_q      <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SWAP_IDLE:    if (swap_req_i) state_d = SWAP_PENDING;
            SWAP_PENDING: if (boundary)   state_d = SWAP_IDLE;
        endcase
    end

    // A request landing on the boundary itself only arms the next frame
    always_comb begin
        apply      = (state_q == SWAP_PENDING) && boundary;
        disp_buf_d = disp_buf_q ^ apply;
        ack_d      = apply;
    end

    assign fb_addr_o  = addr_q;
    assign swap_ack_o = ack_q;
    assign disp_buf_o = disp_buf_q;
    assign h_sync_o   = hs_q[PIX_LAT-1];
    assign v_sync_o   = vs_q[PIX_LAT-1];

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch with a registered framebuffer RAM model.
module tb_vga_pixel_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  h, v;
    logic        von, hs, vs;
    logic [15:0] fb_addr;
    logic [3:0]  fb_data;
    logic        pal_we;
    logic [3:0]  pal_addr;
    logic [11:0] pal_data;
    logic        swap_req, swap_ack, disp_buf;
    logic [11:0] rgb;
    logic        hs_o, vs_o;
    logic [3:0]  ram_val;

    int n_chk = 0;
    int n_err = 0;

    always #20 clk = ~clk;

    // Synchronous RAM: data valid one cycle after the address
    always @(posedge clk) fb_data <= ram_val;

    vga_pixel_fetch dut (
        .block_clk_i (clk),
        .rst_i       (rst),
        .h_count_i   (h),
        .v_count_i   (v),
        .video_on_i  (von),
        .h_sync_i    (hs),
        .v_sync_i    (vs),
        .fb_addr_o   (fb_addr),
        .fb_data_i   (fb_data),
        .pal_we_i    (pal_we),
        .pal_addr_i  (pal_addr),
        .pal_data_i  (pal_data),
        .swap_req_i  (swap_req),
        .swap_ack_o  (swap_ack),
        .disp_buf_o  (disp_buf),
        .rgb_o       (rgb),
        .h_sync_o    (hs_o),
        .v_sync_o    (vs_o)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; h = '0; v = '0; von = 1'b0; hs = 1'b1; vs = 1'b1;
        pal_we = 1'b0; pal_addr = '0; pal_data = '0; swap_req = 1'b0;
        ram_val = 4'h0;
        #5;
        check("rst_rgb", 32'(rgb), 32'h0);
        check("rst_hs", 32'(hs_o), 32'h1);
        check("rst_vs", 32'(vs_o), 32'h1);
        check("rst_addr", 32'(fb_addr), 32'h0);
        check("rst_buf", 32'(disp_buf), 32'h0);
        check("rst_ack", 32'(swap_ack), 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // Address stage
        h = 10'd4; v = 10'd4; von = 1'b1;
        tick();
        check("addr_4_4", 32'(fb_addr), 32'h00A1);
        h = 10'd639; v = 10'd479;
        tick();
        check("addr_max", 32'(fb_addr), 32'h4AFF);
        von = 1'b0; h = 10'd640;
        tick();
        check("addr_blank", 32'(fb_addr), 32'h0);
        for (int i = 0; i < 3; i++) tick();

        // Latency: one active pixel with syncs asserted alongside it
        ram_val = 4'h5;
        tick();
        h = 10'd8; v = 10'd8; von = 1'b1; hs = 1'b0; vs = 1'b0;
        tick();
        von = 1'b0; hs = 1'b1; vs = 1'b1; h = 10'd700;
        check("lat1_rgb", 32'(rgb), 32'h0);
        check("lat1_hs", 32'(hs_o), 32'h1);
        tick();
        check("lat2_rgb", 32'(rgb), 32'h0);
        check("lat2_vs", 32'(vs_o), 32'h1);
        tick();
        check("lat3_rgb", 32'(rgb), 32'h555);
        check("lat3_hs", 32'(hs_o), 32'h0);
        check("lat3_vs", 32'(vs_o), 32'h0);
        tick();
        check("lat4_rgb", 32'(rgb), 32'h0);
        check("lat4_hs", 32'(hs_o), 32'h1);

        // Blanking forces black even with a bright index
        ram_val = 4'hF;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("blank_rgb", 32'(rgb), 32'h0);
        end

        // Same-cycle palette write and lookup of entry 5
        ram_val = 4'h5;
        tick();
        von = 1'b1; h = 10'd12;
        tick();
        von = 1'b0;
        tick();
        pal_we = 1'b1; pal_addr = 4'd5; pal_data = 12'hF00;
        tick();
        pal_we = 1'b0;
        check("pal_old", 32'(rgb), 32'h555);
        von = 1'b1;
        tick();
        von = 1'b0;
        tick();
        tick();
        check("pal_new", 32'(rgb), 32'hF00);
        ram_val = 4'h3;
        von = 1'b1;
        tick();
        von = 1'b0;
        tick();
        tick();
        check("pal_grey3", 32'(rgb), 32'h333);

        // Buffer swap
        v = 10'd100; h = 10'd0; swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        check("swap_wait_buf", 32'(disp_buf), 32'h0);
        check("swap_wait_ack", 32'(swap_ack), 32'h0);
        v = 10'd479;
        tick();
        check("swap_479_buf", 32'(disp_buf), 32'h0);
        v = 10'd480; h = 10'd0;
        tick();
        check("swap_buf", 32'(disp_buf), 32'h1);
        check("swap_ack", 32'(swap_ack), 32'h1);
        h = 10'd1;
        tick();
        check("swap_ack_off", 32'(swap_ack), 32'h0);
        check("swap_buf_hold", 32'(disp_buf), 32'h1);
        v = 10'd0; h = 10'd0; von = 1'b1;
        tick();
        von = 1'b0;
        check("swap_addr_msb", 32'(fb_addr), 32'h8000);

        // Request on the boundary cycle waits a frame
        v = 10'd480; h = 10'd0; swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        check("bnd_buf", 32'(disp_buf), 32'h1);
        check("bnd_ack", 32'(swap_ack), 32'h0);
        h = 10'd1;
        tick();
        check("bnd_buf2", 32'(disp_buf), 32'h1);
        h = 10'd0;
        tick();
        check("bnd_next_buf", 32'(disp_buf), 32'h0);
        check("bnd_next_ack", 32'(swap_ack), 32'h1);

        // Mid-frame reset with a live pipeline
        v = 10'd8; h = 10'd8; von = 1'b1; hs = 1'b0; vs = 1'b0; ram_val = 4'h5;
        tick();
        tick();
        tick();
        check("pre_rst_rgb", 32'(rgb), 32'hF00);
        #5;
        rst = 1'b1;
        #1;
        check("mid_rst_rgb", 32'(rgb), 32'h0);
        check("mid_rst_hs", 32'(hs_o), 32'h1);
        check("mid_rst_addr", 32'(fb_addr), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("post1_rgb", 32'(rgb), 32'h0);
        check("post1_hs", 32'(hs_o), 32'h1);
        tick();
        check("post2_rgb", 32'(rgb), 32'h0);
        tick();
        check("post3_rgb", 32'(rgb), 32'h555);
        check("post3_hs", 32'(hs_o), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
